mem_bist: RTL and testbench

//  Bus initiator that drives the single-port mem responder port (addr/we/wd/rd) to run a

---
 rtl/mem_bist.sv | 119 +++++++++++
 tb/tb_mem_bist.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist.sv
// mem_bist: March-style memory self test (ascending write P, read P / write ~P, descending read ~P)
// with pass/fail reporting, saturating error count and first-failure capture.
module mem_bist #(
    parameter int depth = 8,
    parameter int a_w   = $clog2(depth),
    parameter int d_w   = 32,
    parameter int b_c   = 4,
    parameter int e_w   = 8
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [d_w-1:0] pat,
    output logic [a_w-1:0] addr,
    output logic [b_c-1:0] we,
    output logic [d_w-1:0] wd,
    input  logic [d_w-1:0] rd,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [e_w-1:0] err_cnt,
    output logic [a_w-1:0] fail_addr,
    output logic [d_w-1:0] fail_exp,
    output logic [d_w-1:0] fail_got
);
    localparam logic [2:0] IDLE = 3'd0, W0 = 3'd1, R0 = 3'd2, W1 = 3'd3, R1 = 3'd4, DONE = 3'd5;
    localparam logic [a_w-1:0] LAST = a_w'(depth - 1);

    logic [2:0]     state_q, state_d;
    logic [a_w-1:0] addr_q, addr_d, fail_addr_q, fail_addr_d;
    logic [d_w-1:0] pat_q, pat_d, fail_exp_q, fail_exp_d, fail_got_q, fail_got_d, exp_w;
    logic [e_w-1:0] err_cnt_q, err_cnt_d;
    logic           pass_q, pass_d, at_last, at_zero, miss;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pat_d       = pat_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        pass_d      = pass_q;
        at_last     = addr_q == LAST;
        at_zero     = addr_q == '0;
        exp_w       = state_q == R0 ? pat_q : ~pat_q;
        miss        = (state_q == R0 || state_q == R1) && rd != exp_w;
        case (state_q)
            IDLE: if (start) begin
                state_d     = W0;
                pat_d       = pat;
                addr_d      = '0;
                err_cnt_d   = '0;
                fail_addr_d = '0;
                fail_exp_d  = '0;
                fail_got_d  = '0;
                pass_d      = 1'b0;
            end
            W0: begin
                state_d = at_last ? R0 : W0;
                addr_d  = at_last ? '0 : addr_q + 1'b1;
            end
            R0: state_d = W1;
            W1: begin
                state_d = at_last ? R1 : R0;
                addr_d  = at_last ? addr_q : addr_q + 1'b1;
            end
            R1: begin
                state_d = at_zero ? DONE : R1;
                addr_d  = at_zero ? addr_q : addr_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // only the first mismatch of a run is captured; the count then saturates
        if (miss) begin
            err_cnt_d = err_cnt_q == '1 ? err_cnt_q : err_cnt_q + 1'b1;
            if (err_cnt_q == '0) begin
                fail_addr_d = addr_q;
                fail_exp_d  = exp_w;
                fail_got_d  = rd;
            end
        end
        if (state_q == R1 && at_zero)
            pass_d = err_cnt_d == '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            pat_q       <= '0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pat_q       <= pat_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
            pass_q      <= pass_d;
        end
    end

    assign addr      = addr_q;
    assign we        = {b_c{state_q == W0 || state_q == W1}};
    assign wd        = state_q == W0 ? pat_q : state_q == W1 ? ~pat_q : '0;
    assign busy      = state_q == W0 || state_q == R0 || state_q == W1 || state_q == R1;
    assign done      = state_q == DONE;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_got  = fail_got_q;
endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: directed bench for mem_bist with three instances: depth 8 with optional read fault,
// depth 8 / e_w 2 on a stuck-at-zero responder, and depth 5 fault-free.
module tb_mem_bist;
    localparam logic [31:0] P  = 32'hA5A5_5AA5;
    localparam logic [31:0] NP = 32'h5A5A_A55A;

    logic clk = 1'b0, resetn = 1'b0;
    logic [31:0] pat = P;
    logic [2:0] start_v = '0;
    int checks = 0, failures = 0, mode = 0;

    logic [2:0] addr8, fa8, addr2, fa2, addr5, fa5;
    logic [3:0] we8, we2, we5;
    logic [31:0] wd8, rd8, fe8, fg8, wd2, fe2, fg2, wd5, rd5, fe5, fg5;
    logic busy8, done8, pass8, busy2, done2, pass2, busy5, done5, pass5;
    logic [7:0] err8, err5;
    logic [1:0] err2;
    logic [31:0] mem8 [8];
    logic [31:0] mem5 [8];

    logic [2:0] done_v, busy_v, we_v;
    logic [2:0] addr_v [3];
    logic [2:0] addr_log[$], exp_a[$];
    logic we_log[$], exp_w[$];

    always #5 clk = ~clk;

    mem_bist #(.depth(8), .e_w(8)) dut8 (.clk(clk), .resetn(resetn), .start(start_v[0]), .pat(pat),
        .addr(addr8), .we(we8), .wd(wd8), .rd(rd8), .busy(busy8), .done(done8), .pass(pass8),
        .err_cnt(err8), .fail_addr(fa8), .fail_exp(fe8), .fail_got(fg8));
    mem_bist #(.depth(8), .e_w(2)) dut2 (.clk(clk), .resetn(resetn), .start(start_v[1]), .pat(pat),
        .addr(addr2), .we(we2), .wd(wd2), .rd(32'h0), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .fail_addr(fa2), .fail_exp(fe2), .fail_got(fg2));
    mem_bist #(.depth(5), .e_w(8)) dut5 (.clk(clk), .resetn(resetn), .start(start_v[2]), .pat(pat),
        .addr(addr5), .we(we5), .wd(wd5), .rd(rd5), .busy(busy5), .done(done5), .pass(pass5),
        .err_cnt(err5), .fail_addr(fa5), .fail_exp(fe5), .fail_got(fg5));

    always @(posedge clk) begin
        if (|we8) mem8[addr8] <= wd8;
        if (|we5) mem5[addr5] <= wd5;
    end
    // mode 1: bit 3 of the word at address 5 reads back as 0
    assign rd8 = (mode == 1 && addr8 == 3'd5) ? mem8[addr8] & ~32'h8 : mem8[addr8];
    assign rd5 = mem5[addr5];

    assign done_v = {done5, done2, done8};
    assign busy_v = {busy5, busy2, busy8};
    assign we_v   = {|we5, |we2, |we8};
    assign addr_v[0] = addr8;
    assign addr_v[1] = addr2;
    assign addr_v[2] = addr5;

    // start instance i, log addr/we each busy cycle, return cycles from accepting edge to done
    task automatic go(input int i, input int pulse_at, input bit hold, output int cyc);
        addr_log.delete();
        we_log.delete();
        @(negedge clk);
        start_v[i] = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        while (!done_v[i] && cyc < 200) begin
            start_v[i] = hold || cyc == pulse_at;
            if (busy_v[i]) begin
                addr_log.push_back(addr_v[i]);
                we_log.push_back(we_v[i]);
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        start_v[i] = hold;
    endtask

    function automatic void build_seq(input int d);
        exp_a.delete();
        exp_w.delete();
        for (int a = 0; a < d; a++) begin exp_a.push_back(3'(a)); exp_w.push_back(1'b1); end
        for (int a = 0; a < d; a++) begin
            exp_a.push_back(3'(a)); exp_w.push_back(1'b0);
            exp_a.push_back(3'(a)); exp_w.push_back(1'b1);
        end
        for (int a = d - 1; a >= 0; a--) begin exp_a.push_back(3'(a)); exp_w.push_back(1'b0); end
    endfunction

    task automatic test_reset;
        checks++;
        if ({addr8, we8, wd8, busy8, done8, pass8, err8, fa8, fe8, fg8} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got addr=%0d we=%h wd=%h busy=%b done=%b pass=%b err=%0d fa=%0d fe=%h fg=%h want all 0",
                     addr8, we8, wd8, busy8, done8, pass8, err8, fa8, fe8, fg8);
        end
    endtask

    task automatic test_pass;
        int cyc, bad;
        go(0, 0, 1'b0, cyc);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL pass_latency got %0d want 33", cyc); end
        checks++; if (pass8 !== 1'b1 || busy8 !== 1'b0) begin failures++; $display("FAIL pass_flag got pass=%b busy=%b want pass=1 busy=0", pass8, busy8); end
        checks++; if (err8 !== 8'd0) begin failures++; $display("FAIL pass_errcnt got %0d want 0", err8); end
        build_seq(8);
        bad = -1;
        foreach (exp_a[k]) if (bad < 0 && (k >= addr_log.size() || addr_log[k] !== exp_a[k] || we_log[k] !== exp_w[k])) bad = k;
        checks++;
        if (bad >= 0 || addr_log.size() != 32) begin
            failures++;
            $display("FAIL pass_addr_seq got len=%0d first_bad=%0d want len=32 matching March order", addr_log.size(), bad);
        end
        @(negedge clk);
        checks++; if (done8 !== 1'b0 || pass8 !== 1'b1) begin failures++; $display("FAIL pass_done_pulse got done=%b pass=%b want done=0 pass=1", done8, pass8); end
    endtask

    task automatic test_fault;
        int cyc;
        mode = 1;
        go(0, 0, 1'b0, cyc);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL fault_latency got %0d want 33", cyc); end
        checks++; if (err8 !== 8'd1) begin failures++; $display("FAIL fault_errcnt got %0d want 1", err8); end
        checks++; if (fa8 !== 3'd5) begin failures++; $display("FAIL fault_addr got %0d want 5", fa8); end
        checks++; if (fe8 !== NP) begin failures++; $display("FAIL fault_exp got %h want %h", fe8, NP); end
        checks++; if (fg8 !== 32'h5A5A_A552) begin failures++; $display("FAIL fault_got got %h want 5a5aa552", fg8); end
        checks++; if (pass8 !== 1'b0) begin failures++; $display("FAIL fault_pass got %b want 0", pass8); end
        mode = 0;
    endtask

    task automatic test_saturate;
        int cyc;
        go(1, 0, 1'b0, cyc);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL sat_latency got %0d want 33", cyc); end
        checks++; if (err2 !== 2'd3) begin failures++; $display("FAIL sat_errcnt got %0d want 3", err2); end
        checks++; if (fa2 !== 3'd0 || fe2 !== P || fg2 !== 32'h0) begin failures++; $display("FAIL sat_capture got fa=%0d fe=%h fg=%h want 0 %h 0", fa2, fe2, fg2, P); end
        checks++; if (pass2 !== 1'b0) begin failures++; $display("FAIL sat_pass got %b want 0", pass2); end
    endtask

    task automatic test_start_ignored;
        int cyc;
        go(0, 10, 1'b0, cyc);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL ignore_latency got %0d want 33", cyc); end
        checks++; if (pass8 !== 1'b1 || err8 !== 8'd0) begin failures++; $display("FAIL ignore_result got pass=%b err=%0d want 1 0", pass8, err8); end
    endtask

    task automatic test_back_to_back;
        int cyc, n;
        go(0, 0, 1'b1, cyc);
        n = 0;
        @(posedge clk); n++; @(negedge clk);
        while (!done8 && n < 100) begin @(posedge clk); n++; @(negedge clk); end
        start_v[0] = 1'b0;
        checks++; if (n !== 34) begin failures++; $display("FAIL b2b_restart got %0d want 34 edges between done pulses", n); end
        checks++; if (pass8 !== 1'b1) begin failures++; $display("FAIL b2b_pass got %b want 1", pass8); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc, seen;
        @(negedge clk); start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); start_v[0] = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        checks++; if (addr8 !== 3'd1 || we8 !== 4'h0 || busy8 !== 1'b1) begin failures++; $display("FAIL mid_state got addr=%0d we=%h busy=%b want 1 0 1", addr8, we8, busy8); end
        resetn = 1'b0;
        #1;
        checks++;
        if ({addr8, we8, wd8, busy8, done8, pass8, err8, fa8, fe8, fg8} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got addr=%0d we=%h wd=%h busy=%b done=%b err=%0d want all 0", addr8, we8, wd8, busy8, done8, err8);
        end
        seen = 0;
        repeat (3) begin @(negedge clk); seen |= done8; end
        resetn = 1'b1;
        repeat (40) begin @(negedge clk); seen |= done8; end
        checks++; if (seen !== 0) begin failures++; $display("FAIL mid_no_done got done seen=%0d want 0", seen); end
        go(0, 0, 1'b0, cyc);
        checks++; if (cyc !== 33 || pass8 !== 1'b1) begin failures++; $display("FAIL mid_rerun got cyc=%0d pass=%b want 33 1", cyc, pass8); end
    endtask

    task automatic test_depth5;
        int cyc, bad, mx;
        go(2, 0, 1'b0, cyc);
        checks++; if (cyc !== 21) begin failures++; $display("FAIL d5_latency got %0d want 21", cyc); end
        checks++; if (pass5 !== 1'b1 || err5 !== 8'd0) begin failures++; $display("FAIL d5_result got pass=%b err=%0d want 1 0", pass5, err5); end
        build_seq(5);
        bad = -1;
        mx = 0;
        foreach (addr_log[k]) if (int'(addr_log[k]) > mx) mx = int'(addr_log[k]);
        foreach (exp_a[k]) if (bad < 0 && (k >= addr_log.size() || addr_log[k] !== exp_a[k] || we_log[k] !== exp_w[k])) bad = k;
        checks++;
        if (bad >= 0 || addr_log.size() != 20) begin
            failures++;
            $display("FAIL d5_addr_seq got len=%0d first_bad=%0d want len=20 matching March order", addr_log.size(), bad);
        end
        checks++; if (mx > 4) begin failures++; $display("FAIL d5_addr_max got %0d want <=4", mx); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        resetn = 1'b1;
        test_pass;
        test_fault;
        test_saturate;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid;
        test_depth5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
